// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings,
// IMEM base address and the checksum fold helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [31:0] IMEM_BASE = 32'h0000_0000;

    function automatic logic [7:0] xor_byte(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; word_valid is combinational
// and fires with the 4th byte so the loader can register the write one cycle later.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] shift;

    // byte counter and shift register for the first three bytes of a word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 2'd0;
            shift <= 24'd0;
        end else if (clear) begin
            cnt   <= 2'd0;
            shift <= 24'd0;
        end else if (in_valid) begin
            cnt   <= cnt + 2'd1;
            shift <= {shift[15:0], in_data};
        end
    end

    assign word_valid = in_valid && (cnt == 2'd3) && !clear;
    assign word       = {shift, in_data};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program image from a byte stream into instruction RAM and
// holds the CPU in reset until done. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        reload,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int IDX_W = $clog2(IMEM_WORDS) + 1;

    state_t           state;
    state_t           next_state;
    logic [7:0]       len_hi;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] hdr;
    logic [IDX_W-1:0] word_idx;
    logic             reload_ok;
    logic             pack_valid;
    logic             word_valid;
    logic             last_word;
    logic             all_written;
    logic [31:0]      word;

    assign hdr         = CNT_W'({len_hi, rx_data});
    assign reload_ok   = reload && ((state == DONE) || (state == ERR));
    assign all_written = (32'(word_idx) == 32'(n_words));
    assign last_word   = ((32'(word_idx) + 32'd1) == 32'(n_words));
    // bytes past the last word must not start a phantom word
    assign pack_valid  = rx_valid && (state == DATA) && !all_written;

    imem_loader_byte_packer u_byte_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (reload_ok),
        .in_valid   (pack_valid),
        .in_data    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // running XOR of payload bytes, restarted at each header
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'h00;
        end else if (reload_ok || ((state == LEN_LO) && rx_valid)) begin
            csum <= 8'h00;
        end else if (pack_valid) begin
            csum <= xor_byte(csum, rx_data);
        end
    end
`endif

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            LEN_HI: begin
                if (rx_valid) next_state = LEN_LO;
                else          next_state = state;
            end
            LEN_LO: begin
                if (!rx_valid)                          next_state = state;
`ifdef IMEM_LOADER_CHECKSUM_EN
                else if (hdr == {CNT_W{1'b0}})          next_state = CSUM;
`else
                else if (hdr == {CNT_W{1'b0}})          next_state = DONE;
`endif
                else if (32'(hdr) > 32'(IMEM_WORDS))    next_state = ERR;
                else                                    next_state = DATA;
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (word_valid && last_word) next_state = CSUM;
                else                         next_state = state;
`else
                // waiting one cycle past the last write keeps DONE after the final wr_en
                if (all_written) next_state = DONE;
                else             next_state = state;
`endif
            end
            CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (!rx_valid)            next_state = state;
                else if (rx_data == csum) next_state = DONE;
                else                      next_state = ERR;
`else
                next_state = ERR;
`endif
            end
            DONE, ERR: begin
                if (reload) next_state = LEN_HI;
                else        next_state = state;
            end
            default: next_state = LEN_HI;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LEN_HI;
            len_hi    <= 8'h00;
            n_words   <= {CNT_W{1'b0}};
            word_idx  <= {IDX_W{1'b0}};
            wr_en     <= 1'b0;
            wr_addr   <= IMEM_BASE;
            wr_data   <= 32'h0000_0000;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= next_state;
            cpu_hold  <= (next_state != DONE);
            load_done <= (next_state == DONE);
            load_err  <= (next_state == ERR);
            wr_en     <= word_valid;
            if ((state == LEN_HI) && rx_valid) begin
                len_hi <= rx_data;
            end
            if ((state == LEN_LO) && rx_valid) begin
                n_words  <= hdr;
                word_idx <= {IDX_W{1'b0}};
            end else if (word_valid) begin
                wr_data  <= word;
                wr_addr  <= IMEM_BASE + {{(32-IDX_W-2){1'b0}}, word_idx, 2'b00};
                word_idx <= word_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            end else if (reload_ok) begin
                word_idx <= {IDX_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes expected writes as it sends
// each word's final byte; an independent monitor pops and compares on every wr_en.
module tb_imem_loader;

    localparam int IMEM_WORDS = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    imem_loader #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .reload    (reload),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] pay[IMEM_WORDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // reference model: XOR over the big-endian bytes of the first n payload words
    function automatic logic [7:0] model_xor(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            x = x ^ pay[w][31:24] ^ pay[w][23:16] ^ pay[w][15:8] ^ pay[w][7:0];
        end
        return x;
    endfunction

    function automatic bit model_done(input int hdr, input bit bad);
        return (hdr <= IMEM_WORDS) && !(CSUM_EN && bad);
    endfunction

    // monitor: every write must match the oldest expectation
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
                check("wr_latency", 32'(cyc), 32'(e.cyc));
                check("hold_during_write", 32'(cpu_hold), 32'd1);
            end
        end
    end

    task automatic drive_begin(input logic [7:0] b, input bit rl);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        reload   = rl;
    endtask

    task automatic drive_end(input bit b2b);
        if (!b2b) begin
            @(negedge clk);
            rx_valid = 1'b0;
            reload   = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic frame_end();
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic send_frame(input int hdr, input bit b2b, input bit bad_csum,
                              input int abort_at, input int reload_at);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] w;
        wr_t         e;
        h = 16'(hdr);
        drive_begin(h[15:8], 1'b0); drive_end(b2b);
        drive_begin(h[7:0], 1'b0);  drive_end(b2b);
        if (hdr <= IMEM_WORDS) begin
            for (int i = 0; i < 4 * hdr && (abort_at < 0 || i < abort_at); i++) begin
                w = pay[i / 4];
                b = w[8 * (3 - (i % 4)) +: 8];
                drive_begin(b, reload_at == i);
                if (i % 4 == 3) begin
                    e.addr = 32'(4 * (i / 4));
                    e.data = w;
                    e.cyc  = cyc + 1;
                    exp_q.push_back(e);
                end
                drive_end(b2b);
            end
            if (CSUM_EN && abort_at < 0) begin
                b = model_xor(hdr) ^ {7'd0, bad_csum};
                drive_begin(b, 1'b0); drive_end(b2b);
            end
        end
        frame_end();
    endtask

    task automatic check_status(input string tag, input bit exp_done);
        repeat (4) @(negedge clk);
        check({tag, "_done"},    32'(load_done),      32'(exp_done));
        check({tag, "_err"},     32'(load_err),       32'(!exp_done));
        check({tag, "_hold"},    32'(cpu_hold),       32'(!exp_done));
        check({tag, "_pending"}, 32'(exp_q.size()),   32'd0);
    endtask

    task automatic do_reload();
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        check("reload_done", 32'(load_done), 32'd0);
        check("reload_err",  32'(load_err),  32'd0);
        check("reload_hold", 32'(cpu_hold),  32'd1);
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) begin
            drive_begin(8'($urandom), 1'b0);
        end
        frame_end();
    endtask

    initial begin
        int hdr;
        bit b2b;
        bit bad;
        int rl;

        // reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_hold",  32'(cpu_hold),  32'd1);
        check("rst_wr_en", 32'(wr_en),     32'd0);
        check("rst_done",  32'(load_done), 32'd0);
        check("rst_err",   32'(load_err),  32'd0);
        check("rst_addr",  wr_addr,        32'd0);
        check("rst_data",  wr_data,        32'd0);

        // two-word program
        pay[0] = 32'h3C15_4000;
        pay[1] = 32'h2009_0000;
        send_frame(2, 1'b0, 1'b0, -1, -1);
        check_status("prog2", 1'b1);
        send_junk(3);
        check_status("done_ignores", 1'b1);
        do_reload();

        // empty image
        send_frame(0, 1'b0, 1'b0, -1, -1);
        check_status("empty", 1'b1);
        do_reload();

        // oversize header, bytes ignored in ERR, then recovery
        send_frame(16'h0101, 1'b0, 1'b0, -1, -1);
        check_status("oversize", 1'b0);
        send_junk(6);
        check_status("err_ignores", 1'b0);
        do_reload();
        send_frame(2, 1'b1, 1'b0, -1, -1);
        check_status("after_err", 1'b1);
        do_reload();

        // back-to-back N=3, then reset mid-frame and resend
        for (int w = 0; w < 3; w++) pay[w] = $urandom;
        send_frame(3, 1'b1, 1'b0, -1, -1);
        check_status("b2b3", 1'b1);
        do_reload();
        send_frame(3, 1'b1, 1'b0, 5, -1);
        repeat (3) @(negedge clk);
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_hold", 32'(cpu_hold),  32'd1);
        check("midrst_done", 32'(load_done), 32'd0);
        send_frame(3, 1'b1, 1'b0, -1, -1);
        check_status("resend", 1'b1);
        do_reload();

        // capacity boundary: exactly IMEM_WORDS, then one more
        for (int w = 0; w < IMEM_WORDS; w++) pay[w] = $urandom;
        send_frame(IMEM_WORDS, 1'b1, 1'b0, -1, -1);
        check_status("full", 1'b1);
        do_reload();
        send_frame(IMEM_WORDS + 1, 1'b1, 1'b0, -1, -1);
        check_status("full_plus1", 1'b0);
        do_reload();

`ifdef IMEM_LOADER_CHECKSUM_EN
        pay[0] = 32'h1122_3344;
        send_frame(1, 1'b0, 1'b0, -1, -1);
        check_status("csum_ok", 1'b1);
        do_reload();
        send_frame(1, 1'b0, 1'b1, -1, -1);
        check_status("csum_bad", 1'b0);
        do_reload();
`endif

        // randomized frames, some with an ignored reload mid-payload
        for (int f = 0; f < 12; f++) begin
            hdr = ($urandom_range(0, 5) == 0) ? 257 + $urandom_range(0, 500) : $urandom_range(0, 6);
            for (int w = 0; w < hdr && w < IMEM_WORDS; w++) pay[w] = $urandom;
            b2b = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 2) == 0);
            rl  = (hdr > 0 && hdr <= IMEM_WORDS && $urandom_range(0, 1) == 1) ?
                  $urandom_range(0, 4 * hdr - 1) : -1;
            send_frame(hdr, b2b, bad, -1, rl);
            check_status("rand", model_done(hdr, bad));
            do_reload();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
